a_filter_tdm: RTL and testbench

Parametrised, time-multiplexed cascade of first-order all-pass sections: STAGES sections share one multiply-add datapath and are evaluated one per clock cycle. It succeeds the fixed 32x11, six-instance all-pass cascade. Width, depth and coefficients are now parameters or run-time programmable, and the block adds a valid/ready stream interface, a per-stage bypass and a flush. It sits in the audio/DSP filter chain between the sample source and downstream consumers.

---
 rtl/a_filter_pkg.sv | 29 ++
 rtl/fos_tdm_pe.sv | 48 ++++
 rtl/a_filter_tdm.sv | 127 ++++++++++++
 tb/tb_a_filter_tdm.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/a_filter_pkg.sv
// Shared definitions for the time-multiplexed all-pass cascade.
//   state_e      : sequencer states (idle / run / out)
//   COEF_FRAC    : fractional bits of the default Q1.10 coefficient format
//   coef_frac()  : fractional bits for an arbitrary coefficient width
//   LEGACY_A*    : coefficients reproducing the six-stage legacy response
package a_filter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StOut
    } state_e;

    localparam int unsigned COEF_W_DEF = 11;
    localparam int unsigned COEF_FRAC  = COEF_W_DEF - 1;

    localparam int LEGACY_A0 = -1010;
    localparam int LEGACY_A1 = -930;
    localparam int LEGACY_A2 = -1021;
    localparam int LEGACY_A3 = -1021;
    localparam int LEGACY_A4 = -208;
    localparam int LEGACY_A5 = -208;

    // Q1.(w-1): one sign/integer bit, the rest fractional.
    function automatic int unsigned coef_frac(input int unsigned coef_w);
        return coef_w - 1;
    endfunction

endpackage

// File: rtl/fos_tdm_pe.sv
// Combinational datapath of one transposed first-order all-pass section.
//   x      : section input sample
//   a      : signed Q1.(COEF_W-1) coefficient
//   s      : current section state
//   byp    : bypass, passes x through and leaves the state untouched
//   y      : section output, ((a*x) >>> frac) + s
//   s_next : updated state, x - ((a*y) >>> frac)
module fos_tdm_pe
    import a_filter_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned COEF_W = 11
) (
    input  logic [DATA_W-1:0] x,
    input  logic [COEF_W-1:0] a,
    input  logic [DATA_W-1:0] s,
    input  logic              byp,
    output logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] s_next
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned FRAC   = coef_frac(COEF_W);

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] ax;
    logic signed [PROD_W-1:0] ay;
    logic        [DATA_W-1:0] y_mac;
    logic        [DATA_W-1:0] s_mac;

    always_comb begin
        // Both operands sign-extended to the full product width so the
        // product is exact before the arithmetic (floor) shift.
        a_ext = PROD_W'($signed(a));
        ax    = a_ext * PROD_W'($signed(x));
        y_mac = DATA_W'(ax >>> FRAC) + s;
        ay    = a_ext * PROD_W'($signed(y_mac));
        s_mac = x - DATA_W'(ay >>> FRAC);
        if (byp) begin
            y      = x;
            s_next = s;
        end else begin
            y      = y_mac;
            s_next = s_mac;
        end
    end

endmodule

// File: rtl/a_filter_tdm.sv
// Time-multiplexed cascade of STAGES first-order all-pass sections sharing
// one multiply-add datapath, one section evaluated per clock.
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, in_ready high only while idle
//   x_in                : input sample
//   out_valid/out_ready : output handshake, y_out held until consumed
//   y_out               : filtered sample (the working register)
//   coef_we/addr/wdata  : coefficient write port, out-of-range addresses ignored
//   coef_byp            : bypass flag written together with the coefficient
//   flush               : zero all section states and return to idle
module a_filter_tdm
    import a_filter_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned COEF_W = 11,
    parameter int unsigned STAGES = 6
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [DATA_W-1:0]                             x_in,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [DATA_W-1:0]                             y_out,
    input  logic                                          coef_we,
    input  logic [((STAGES > 1) ? $clog2(STAGES) : 1)-1:0] coef_addr,
    input  logic [COEF_W-1:0]                             coef_wdata,
    input  logic                                          coef_byp,
    input  logic                                          flush
);

    localparam int unsigned IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    state_e              state_q;
    logic [IDX_W-1:0]    k_q;
    logic [DATA_W-1:0]   work_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   s_q   [STAGES];
    logic [COEF_W-1:0]   a_q   [STAGES];
    logic                byp_q [STAGES];

    logic [DATA_W-1:0]   pe_y;
    logic [DATA_W-1:0]   pe_s_next;
    logic                addr_ok;
    logic                last_stage;

    fos_tdm_pe #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W)
    ) u_pe (
        .x      (work_q),
        .a      (a_q[k_q]),
        .s      (s_q[k_q]),
        .byp    (byp_q[k_q]),
        .y      (pe_y),
        .s_next (pe_s_next)
    );

    assign addr_ok    = 32'(coef_addr) < STAGES;
    assign last_stage = (k_q == IDX_W'(STAGES - 1));

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = out_valid_q;
    assign y_out      = work_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            k_q         <= '0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < int'(STAGES); i++) begin
                s_q[i]   <= '0;
                a_q[i]   <= '0;
                byp_q[i] <= 1'b0;
            end
        end else begin
            // Coefficient port is independent of the sequencer and of flush;
            // an evaluation on the same edge still sees the old value.
            if (coef_we && addr_ok) begin
                a_q[coef_addr]   <= coef_wdata;
                byp_q[coef_addr] <= coef_byp;
            end

            if (flush) begin
                state_q     <= StIdle;
                k_q         <= '0;
                out_valid_q <= 1'b0;
                for (int i = 0; i < int'(STAGES); i++) begin
                    s_q[i] <= '0;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        if (in_valid) begin
                            work_q  <= x_in;
                            k_q     <= '0;
                            state_q <= StRun;
                        end
                    end
                    StRun: begin
                        work_q   <= pe_y;
                        s_q[k_q] <= pe_s_next;
                        if (last_stage) begin
                            state_q     <= StOut;
                            out_valid_q <= 1'b1;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                    StOut: begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                            state_q     <= StIdle;
                        end
                    end
                    default: begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_a_filter_tdm.sv
module tb_a_filter_tdm;

    localparam int DATA_W = 32;
    localparam int COEF_W = 11;
    localparam int STAGES = 6;
    localparam int FRAC   = COEF_W - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] x_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] y_out;
    logic              coef_we;
    logic [2:0]        coef_addr;
    logic [COEF_W-1:0] coef_wdata;
    logic              coef_byp;
    logic              flush;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cyc_acc  = 0;

    // Reference model: coefficient, bypass and state per section.
    int ma [STAGES];
    bit mb [STAGES];
    int ms [STAGES];

    a_filter_tdm #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .STAGES (STAGES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x_in       (x_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y_out      (y_out),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_byp   (coef_byp),
        .flush      (flush)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint floor_q(input longint p);
        longint q;
        q = p / (longint'(1) << FRAC);
        if ((p % (longint'(1) << FRAC)) != 0 && p < 0) q = q - 1;
        return q;
    endfunction

    // Pushes one sample through the whole cascade in plain integer arithmetic.
    function automatic int model_step(input int x);
        int v;
        int y;
        v = x;
        for (int k = 0; k < STAGES; k++) begin
            if (!mb[k]) begin
                y     = int'(floor_q(longint'(ma[k]) * longint'(v)) + longint'(ms[k]));
                ms[k] = int'(longint'(v) - floor_q(longint'(ma[k]) * longint'(y)));
                v     = y;
            end
        end
        return v;
    endfunction

    task automatic model_clear_states();
        for (int k = 0; k < STAGES; k++) ms[k] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_coef(input int addr, input int a, input bit byp);
        coef_we    = 1'b1;
        coef_addr  = 3'(addr);
        coef_wdata = 11'(a);
        coef_byp   = byp;
        tick();
        coef_we = 1'b0;
        if (addr < STAGES) begin
            ma[addr] = a;
            mb[addr] = byp;
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_clear_states();
    endtask

    task automatic accept(input int x);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        in_valid = 1'b1;
        x_in     = x;
        tick();
        in_valid = 1'b0;
        cyc_acc  = cyc;
    endtask

    task automatic collect(input string tag, input longint exp, input int stall);
        int     n;
        longint hold;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, longint'(out_valid), 1);
        check({tag, "_lat"}, longint'(cyc - cyc_acc), STAGES);
        check({tag, "_y"}, longint'($signed(y_out)), exp);
        hold = longint'(y_out);
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_hold"}, {out_valid, in_ready, y_out}, {1'b1, 1'b0, hold[31:0]});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_done"}, {in_ready, out_valid}, 2'b10);
    endtask

    task automatic sample(input string tag, input int x, input int stall);
        int e;
        e = model_step(x);
        accept(x);
        collect(tag, longint'(e), stall);
    endtask

    int exp_a [8] = '{0, 0, 0, 0, 0, 0, 1000, 0};
    int exp_c [7] = '{512, 768, -384, 192, -96, 48, -24};

    initial begin
        int e;
        int x;
        reset = 1'b0; in_valid = 1'b0; x_in = '0; out_ready = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; coef_byp = 1'b0; flush = 1'b0;
        for (int k = 0; k < STAGES; k++) begin ma[k] = 0; mb[k] = 0; ms[k] = 0; end
        repeat (3) tick();
        check("rst_ready", longint'(in_ready), 1);
        check("rst_valid", longint'(out_valid), 0);
        check("rst_y", longint'(y_out), 0);
        reset = 1'b1;
        tick();

        // Zero coefficients: pure six-sample delay.
        for (int i = 0; i < 8; i++) begin
            x = (i == 0) ? 1000 : 0;
            void'(model_step(x));
            accept(x);
            collect("delay", longint'(exp_a[i]), 0);
        end

        // Stage 2 bypassed: remaining five zero-coefficient stages delay.
        do_flush();
        wr_coef(2, 512, 1'b1);
        for (int i = 0; i < 8; i++) sample("bypass", (i == 0) ? 1000 : 0, 0);

        // Single active stage a=0.5, all others bypassed.
        do_flush();
        wr_coef(0, 512, 1'b0);
        for (int k = 1; k < STAGES; k++) wr_coef(k, 0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            x = (i == 0) ? 1024 : 0;
            void'(model_step(x));
            accept(x);
            collect("single", longint'(exp_c[i]), 0);
        end

        // Backpressure for ten cycles.
        for (int k = 0; k < STAGES; k++) wr_coef(k, 300 - 120 * k, 1'b0);
        sample("bp", 123456, 10);

        // Coefficient write landing on the same edge as stage 3 evaluation.
        sample("pre_same", -77777, 0);
        x = 424242;
        e = model_step(x);
        accept(x);
        repeat (3) tick();
        coef_we = 1'b1; coef_addr = 3'd3; coef_wdata = 11'(700); coef_byp = 1'b0;
        tick();
        coef_we = 1'b0;
        ma[3] = 700;
        collect("same_edge_old", longint'(e), 0);
        wr_coef(STAGES, 1000, 1'b1);
        sample("same_edge_new", 31337, 0);
        sample("ignored_addr", -5000, 0);

        // Flush mid-RUN drops the sample and clears the states.
        accept(99999);
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_clear_states();
        check("flush_idle", longint'(in_ready), 1);
        e = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) e = 1;
            tick();
        end
        check("flush_no_out", longint'(e), 0);
        sample("post_flush", 1000, 0);
        sample("post_flush", 0, 0);

        // Flush and coefficient write together: write still lands.
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 11'(-300); coef_byp = 1'b0;
        do_flush();
        coef_we = 1'b0;
        ma[0] = -300; mb[0] = 1'b0;
        sample("flush_wr", 2000, 0);

        // Randomised traffic, including full-range samples that wrap.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                wr_coef(int'($urandom_range(0, STAGES)), int'($urandom_range(0, 2047)) - 1024,
                        ($urandom_range(0, 3) == 0));
            end
            sample("rand", int'($urandom), int'($urandom_range(0, 3)));
        end

        // Asynchronous reset while holding an output.
        accept(555);
        e = 0;
        while (!out_valid && e < 100) begin tick(); e++; end
        check("pre_rst_valid", longint'(out_valid), 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", longint'(out_valid), 0);
        check("async_rst_y", longint'(y_out), 0);
        check("async_rst_ready", longint'(in_ready), 1);
        tick();
        reset = 1'b1;
        for (int k = 0; k < STAGES; k++) begin ma[k] = 0; mb[k] = 0; ms[k] = 0; end
        sample("after_rst", 4321, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
